// File: rtl/host_cmd_framer.sv
// Expands one parallel host command into the system's command byte protocol
// and serializes each byte as a UART frame with programmable parity and baud.
module host_cmd_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int GAP_BITS   = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [1:0]           CMD_TYPE,
    input  logic [3:0]           CMD_ADDR,
    input  logic [7:0]           CMD_DATA_A,
    input  logic [7:0]           CMD_DATA_B,
    input  logic [3:0]           CMD_FUN,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic [DIV_WIDTH-1:0] BAUD_DIV,
    output logic                 TX_OUT,
    output logic                 BUSY,
    output logic                 BYTE_DONE,
    output logic                 CMD_DONE
);

    localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [2:0] BIT_LAST = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_t;

    state_t state, state_next;

    logic [DIV_WIDTH-1:0]  period_cnt, period_next;
    logic [2:0]            bit_idx, bit_next;
    logic [1:0]            byte_idx, byte_next;
    logic [GAP_W-1:0]      gap_cnt, gap_next;
    logic                  byte_done_q, byte_done_next;
    logic                  cmd_done_q, cmd_done_next;

    logic [DIV_WIDTH-1:0]  div_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [2:0]            num_bytes;
    logic [DATA_WIDTH-1:0] byte_mem [4];

    logic [DATA_WIDTH-1:0] enc [4];
    logic [2:0]            enc_count;
    logic                  accept;
    logic                  bit_end;
    logic                  last_byte;
    logic [DATA_WIDTH-1:0] cur_byte;
    logic                  parity_bit;
    logic                  tx;

    assign accept     = CMD_VALID && (state == IDLE);
    assign bit_end    = (period_cnt == div_q - DIV_WIDTH'(1));
    assign last_byte  = ({1'b0, byte_idx} == num_bytes - 3'd1);
    assign cur_byte   = byte_mem[byte_idx];
    assign parity_bit = par_typ_q ? ~^cur_byte : ^cur_byte;

    always_comb begin
        enc[0]    = '0;
        enc[1]    = '0;
        enc[2]    = '0;
        enc[3]    = '0;
        enc_count = 3'd2;
        unique case (CMD_TYPE)
            2'b00: begin
                enc[0]    = DATA_WIDTH'(8'hAA);
                enc[1]    = DATA_WIDTH'(CMD_ADDR);
                enc[2]    = CMD_DATA_A;
                enc_count = 3'd3;
            end
            2'b01: begin
                enc[0]    = DATA_WIDTH'(8'hBB);
                enc[1]    = DATA_WIDTH'(CMD_ADDR);
            end
            2'b10: begin
                enc[0]    = DATA_WIDTH'(8'hCC);
                enc[1]    = CMD_DATA_A;
                enc[2]    = CMD_DATA_B;
                enc[3]    = DATA_WIDTH'(CMD_FUN);
                enc_count = 3'd4;
            end
            default: begin
                enc[0]    = DATA_WIDTH'(8'hDD);
                enc[1]    = DATA_WIDTH'(CMD_FUN);
            end
        endcase
    end

    // Everything the frame depends on is frozen at accept so the host may
    // retarget its inputs while the current command is still on the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q     <= DIV_WIDTH'(1);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            num_bytes <= 3'd2;
            for (int i = 0; i < 4; i++) byte_mem[i] <= '0;
        end else if (accept) begin
            div_q     <= (BAUD_DIV == '0) ? DIV_WIDTH'(1) : BAUD_DIV;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            num_bytes <= enc_count;
            for (int i = 0; i < 4; i++) byte_mem[i] <= enc[i];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            period_cnt  <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            byte_done_q <= 1'b0;
            cmd_done_q  <= 1'b0;
        end else begin
            state       <= state_next;
            period_cnt  <= period_next;
            bit_idx     <= bit_next;
            byte_idx    <= byte_next;
            gap_cnt     <= gap_next;
            byte_done_q <= byte_done_next;
            cmd_done_q  <= cmd_done_next;
        end
    end

    always_comb begin
        state_next     = state;
        period_next    = period_cnt;
        bit_next       = bit_idx;
        byte_next      = byte_idx;
        gap_next       = gap_cnt;
        byte_done_next = 1'b0;
        cmd_done_next  = 1'b0;
        tx             = 1'b1;
        unique case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    state_next  = START;
                    period_next = '0;
                    bit_next    = '0;
                    byte_next   = '0;
                    gap_next    = '0;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    period_next = '0;
                    bit_next    = '0;
                    state_next  = DATA;
                end else begin
                    period_next = period_cnt + DIV_WIDTH'(1);
                end
            end
            DATA: begin
                tx = cur_byte[bit_idx];
                if (bit_end) begin
                    period_next = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_next = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    period_next = period_cnt + DIV_WIDTH'(1);
                end
            end
            PARITY: begin
                tx = parity_bit;
                if (bit_end) begin
                    period_next = '0;
                    state_next  = STOP;
                end else begin
                    period_next = period_cnt + DIV_WIDTH'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    period_next    = '0;
                    byte_done_next = 1'b1;
                    if (last_byte) begin
                        cmd_done_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        byte_next  = byte_idx + 2'd1;
                        gap_next   = '0;
                        state_next = (GAP_BITS > 0) ? GAP : START;
                    end
                end else begin
                    period_next = period_cnt + DIV_WIDTH'(1);
                end
            end
            GAP: begin
                if (bit_end) begin
                    period_next = '0;
                    if (gap_cnt == GAP_LAST) begin
                        gap_next   = '0;
                        state_next = START;
                    end else begin
                        gap_next = gap_cnt + GAP_W'(1);
                    end
                end else begin
                    period_next = period_cnt + DIV_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is decoded from the state register, so reset forces it high
    // without waiting for a clock edge.
    assign TX_OUT    = tx;
    assign CMD_READY = (state == IDLE);
    assign BUSY      = ~CMD_READY;
    assign BYTE_DONE = byte_done_q;
    assign CMD_DONE  = cmd_done_q;

endmodule

// File: tb/tb_host_cmd_framer.sv
// Randomized bench for host_cmd_framer: a per-cycle line/pulse model is built
// from the byte protocol and compared against the DUT every cycle.
module tb_host_cmd_framer;

    localparam int DIV_W = 16;
    localparam int GAP   = 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             CMD_VALID = 1'b0;
    logic             CMD_READY;
    logic [1:0]       CMD_TYPE = '0;
    logic [3:0]       CMD_ADDR = '0;
    logic [7:0]       CMD_DATA_A = '0;
    logic [7:0]       CMD_DATA_B = '0;
    logic [3:0]       CMD_FUN = '0;
    logic             PAR_EN = 1'b0;
    logic             PAR_TYP = 1'b0;
    logic [DIV_W-1:0] BAUD_DIV = '0;
    logic             TX_OUT;
    logic             BUSY;
    logic             BYTE_DONE;
    logic             CMD_DONE;

    int total = 0;
    int bad   = 0;

    bit expTx[$];
    int doneAt[$];

    host_cmd_framer #(.DATA_WIDTH(8), .DIV_WIDTH(DIV_W), .GAP_BITS(GAP)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
        .CMD_DATA_A(CMD_DATA_A), .CMD_DATA_B(CMD_DATA_B), .CMD_FUN(CMD_FUN),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .BAUD_DIV(BAUD_DIV),
        .TX_OUT(TX_OUT), .BUSY(BUSY), .BYTE_DONE(BYTE_DONE), .CMD_DONE(CMD_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Line waveform as one entry per clock after accept; doneAt lists the
    // cycle offsets at which a byte-complete pulse is due.
    task automatic buildModel(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] fun, input logic pen,
                              input logic ptyp, input logic [DIV_W-1:0] div);
        logic [7:0] bytes[$];
        int d;
        d = (div == 0) ? 1 : int'(div);
        case (t)
            2'd0:    bytes = '{8'hAA, {4'h0, addr}, a};
            2'd1:    bytes = '{8'hBB, {4'h0, addr}};
            2'd2:    bytes = '{8'hCC, a, b, {4'h0, fun}};
            default: bytes = '{8'hDD, {4'h0, fun}};
        endcase
        expTx.delete();
        doneAt.delete();
        foreach (bytes[k]) begin
            bit lvl[$];
            bit oddOnes;
            oddOnes = ($countones(bytes[k]) % 2) == 1;
            lvl.push_back(1'b0);
            for (int j = 0; j < 8; j++) lvl.push_back(bytes[k][j]);
            if (pen) lvl.push_back(ptyp ? !oddOnes : oddOnes);
            lvl.push_back(1'b1);
            foreach (lvl[n]) repeat (d) expTx.push_back(lvl[n]);
            doneAt.push_back(expTx.size());
            if (k < bytes.size() - 1) repeat (GAP * d) expTx.push_back(1'b1);
        end
    endtask

    task automatic acceptCommand(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] a,
                                 input logic [7:0] b, input logic [3:0] fun, input logic pen,
                                 input logic ptyp, input logic [DIV_W-1:0] div);
        int waited;
        waited = 0;
        while (!CMD_READY && waited < 2000) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("ready_before_accept", CMD_READY, 1);
        buildModel(t, addr, a, b, fun, pen, ptyp, div);
        CMD_TYPE = t; CMD_ADDR = addr; CMD_DATA_A = a; CMD_DATA_B = b; CMD_FUN = fun;
        PAR_EN = pen; PAR_TYP = ptyp; BAUD_DIV = div;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] a,
                                 input logic [7:0] b, input logic [3:0] fun, input logic pen,
                                 input logic ptyp, input logic [DIV_W-1:0] div, input bit holdValid);
        acceptCommand(t, addr, a, b, fun, pen, ptyp, div);
        if (!holdValid) CMD_VALID = 1'b0;
        CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom); CMD_DATA_A = 8'($urandom);
        CMD_DATA_B = 8'($urandom); CMD_FUN = 4'($urandom); PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom); BAUD_DIV = DIV_W'($urandom_range(0, 7));
        for (int i = 0; i <= expTx.size(); i++) begin
            bit last;
            bit bd;
            if (i > 0) @(negedge CLK);
            last = (i == expTx.size());
            bd = 1'b0;
            foreach (doneAt[m]) if (doneAt[m] == i) bd = 1'b1;
            checkOutput($sformatf("tx@%0d", i), TX_OUT, last ? 1'b1 : expTx[i]);
            checkOutput($sformatf("byte_done@%0d", i), BYTE_DONE, bd);
            checkOutput($sformatf("cmd_done@%0d", i), CMD_DONE, last);
            checkOutput($sformatf("ready@%0d", i), CMD_READY, last);
            checkOutput($sformatf("busy@%0d", i), BUSY, !last);
        end
    endtask

    // Reset lands inside data bit 3 of the address byte of a write.
    task automatic applyResetMidFrame(input logic [DIV_W-1:0] div);
        int idx;
        acceptCommand(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, div);
        CMD_VALID = 1'b0;
        idx = 15 * int'(div) + 1;
        repeat (idx) @(negedge CLK);
        checkOutput("tx_before_reset", TX_OUT, expTx[idx]);
        checkOutput("busy_before_reset", BUSY, 1);
        RST = 1'b0;
        #1;
        checkOutput("rst_async_tx", TX_OUT, 1);
        checkOutput("rst_async_ready", CMD_READY, 1);
        checkOutput("rst_async_busy", BUSY, 0);
        checkOutput("rst_async_byte_done", BYTE_DONE, 0);
        checkOutput("rst_async_cmd_done", CMD_DONE, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checkOutput("rst_hold_byte_done", BYTE_DONE, 0);
            checkOutput("rst_hold_cmd_done", CMD_DONE, 0);
            checkOutput("rst_hold_tx", TX_OUT, 1);
        end
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("post_rst_byte_done", BYTE_DONE, 0);
        checkOutput("post_rst_cmd_done", CMD_DONE, 0);
    endtask

    initial begin
        bit hold;
        #1;
        checkOutput("reset_tx", TX_OUT, 1);
        checkOutput("reset_ready", CMD_READY, 1);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_byte_done", BYTE_DONE, 0);
        checkOutput("reset_cmd_done", CMD_DONE, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        applyStimulus(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 16'd1, 1'b0);
        repeat (3) @(negedge CLK);
        applyStimulus(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 16'd4, 1'b0);
        applyStimulus(2'd2, 4'h0, 8'h07, 8'h81, 4'h2, 1'b1, 1'b1, 16'd2, 1'b0);
        repeat (2) @(negedge CLK);
        applyStimulus(2'd3, 4'h0, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0, 16'd0, 1'b1);
        applyStimulus(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 16'd0, 1'b0);

        applyResetMidFrame(16'd2);
        applyStimulus(2'd0, 4'h9, 8'hA5, 8'h00, 4'h0, 1'b1, 1'b0, 16'd3, 1'b0);

        for (int r = 0; r < 20; r++) begin
            hold = (r < 19) ? 1'($urandom) : 1'b0;
            applyStimulus(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                          1'($urandom), 1'($urandom), DIV_W'($urandom_range(0, 4)), hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/host_cmd_framer.md
Name: host_cmd_framer

Overview:
- Upstream stimulus/host stage for the configurable multi-clock system; drives the system's UART receive line.
- Accepts one parallel command per handshake and expands it into the system's command byte protocol.
  - Register write: 0xAA, addr, data.
  - Register read: 0xBB, addr.
  - ALU with operands: 0xCC, A, B, fun.
  - ALU without operands: 0xDD, fun.
- Serializes each byte as a UART frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Used in the system testbench and in the host-side bridge. Parity and bit timing are programmable to match the system's UART configuration.

Parameters:
- DATA_WIDTH, 8, width of every protocol byte; fixed at 8 for protocol compatibility.
- DIV_WIDTH, 16, width of the clocks-per-bit divisor.
- GAP_BITS, 1, number of idle (high) bit periods inserted between consecutive bytes of one command; 0 is legal.

Ports:
- CLK  input  1  framer clock.
- RST  input  1  asynchronous active-low reset.
- CMD_VALID  input  1  command request.
- CMD_READY  output  1  framer can accept a command.
- CMD_TYPE  input  2  00 write, 01 read, 10 ALU with operands, 11 ALU without operands.
- CMD_ADDR  input  4  register address; zero-extended to 8 bits.
- CMD_DATA_A  input  8  write data (write) or operand A (ALU with operands).
- CMD_DATA_B  input  8  operand B.
- CMD_FUN  input  4  ALU function; zero-extended to 8 bits.
- PAR_EN  input  1  parity bit enable.
- PAR_TYP  input  1  0 even, 1 odd.
- BAUD_DIV  input  DIV_WIDTH  CLK cycles per bit; 0 is treated as 1.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  command in progress; equals ~CMD_READY.
- BYTE_DONE  output  1  one-cycle pulse after each byte's stop bit.
- CMD_DONE  output  1  one-cycle pulse after the final byte's stop bit.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-low.
- Values while RST is low: TX_OUT=1, CMD_READY=1, BUSY=0, BYTE_DONE=0, CMD_DONE=0. All counters are cleared and the FSM is in IDLE.
- Reset asserted mid-frame: TX_OUT goes high immediately (asynchronously). The command is discarded, and no DONE pulse is issued.
- Handshake:
  - A command is accepted on a rising edge where CMD_VALID and CMD_READY are both high.
  - All CMD_* fields plus PAR_EN, PAR_TYP and BAUD_DIV are captured at that edge. Later changes to these inputs have no effect until the next accept.
- Byte count by type: write 3, read 2, ALU with operands 4, ALU without operands 2.
- FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> GAP or IDLE.
  - GAP is entered only if more bytes remain and GAP_BITS>0.
  - GAP returns to START. If GAP_BITS=0 and more bytes remain, STOP goes directly to START.
- Bit timing:
  - Every bit is held for exactly max(BAUD_DIV,1) cycles.
  - The start bit (TX_OUT=0) begins in the first cycle after the accept edge.
  - Byte duration = (10+PAR_EN)*D cycles, where D = max(BAUD_DIV,1). Gap duration = GAP_BITS*D cycles.
- Data bits: sent LSB first.
- Parity bit: XOR of the 8 data bits when PAR_TYP=0 (even), XNOR when PAR_TYP=1 (odd).
- Completion pulses:
  - BYTE_DONE is high for the one cycle following the last stop-bit cycle of each byte.
  - CMD_DONE coincides with the final byte's BYTE_DONE.
  - In that same cycle CMD_READY returns to 1 and TX_OUT=1.
- Back-to-back commands: a command held valid is accepted at the CMD_DONE cycle edge, so its start bit follows after exactly one idle-high cycle.
- Illegal inputs: none; all CMD_TYPE encodings are defined.
- Counter widths:
  - Bit-period counter: DIV_WIDTH bits.
  - Bit index counter: 0..7.
  - Byte index counter: 0..3.
  - Gap counter: ceil(log2(GAP_BITS+1)) bits.

Test Plan:
- BAUD_DIV=1, PAR_EN=0, GAP_BITS=1; write addr=0x5, data=0x3C -> TX_OUT carries 0xAA, 0x05, 0x3C.
  - Each byte: 0, bits LSB first, 1. One idle bit between bytes.
  - CMD_DONE exactly 3*10+2*1=32 cycles after the accept edge. BYTE_DONE pulses three times.
- Read addr=0xF, PAR_EN=1, PAR_TYP=0, BAUD_DIV=4 -> bytes 0xBB then 0x0F, parity bits 0 and 0.
  - Every bit is held 4 cycles. CMD_DONE at 2*11*4+4 cycles after accept.
- ALU with operands A=0x07, B=0x81, fun=0x2, PAR_EN=1, PAR_TYP=1 -> bytes 0xCC, 0x07, 0x81, 0x02 with odd parity bits 1, 0, 1, 0.
  - CMD_READY stays low throughout.
- CMD_VALID held high for two ALU-without-operands commands (fun=0x1 then 0x3), BAUD_DIV=0 -> treated as 1.
  - Second accept occurs on the CMD_DONE cycle. Exactly one idle-high cycle precedes the next 0xDD start bit.
- BAUD_DIV and PAR_EN changed mid-command -> the current command keeps the captured timing and parity. The new values are used only by the next command.
- RST pulled low during the DATA bit 3 of the second byte -> TX_OUT=1 and CMD_READY=1 asynchronously, with no BYTE_DONE or CMD_DONE.
  - After release, a new write command frames correctly from byte 0.
